// File: rtl/buffer_pkg.sv
// -----------------------------------------------------------------------------
// buffer_pkg
// Shared definitions for the buffer_a matrix buffer:
//   - CMD_* : two-bit command encodings presented on buffer_a.cmd
//   - state_t : control FSM state enumeration
//   - idx_width() : index width needed to address a given number of entries
// Optional feature macro used by the importing files: BUFFER_A_CLEAR_EN
// -----------------------------------------------------------------------------
package buffer_pkg;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_LOAD  = 2'b01;
   localparam logic [1:0] CMD_SEND  = 2'b10;
   localparam logic [1:0] CMD_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SEND  = 2'b10,
      ST_CLEAR = 2'b11
   } state_t;

   // A single-entry array still needs a one-bit index.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/buffer_a_bank.sv
// -----------------------------------------------------------------------------
// buffer_a_bank
// Element storage for buffer_a: MMU_SIZE slots, each an MMU_SIZE x MMU_SIZE
// matrix of VAR_SIZE-bit elements, addressed as [slot][row][col].
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset (clears all)
//   wr_en, wr_slot, wr_row,
//   wr_col, wr_data          : single-element write port
//   clr_en, clr_slot, clr_col: zero one whole column of a slot
//                              (present only with BUFFER_A_CLEAR_EN)
//   rd_slot, rd_col          : column read address
//   rd_column                : combinational column read, row r at
//                              bits [VAR_SIZE*r +: VAR_SIZE]
// Macro: BUFFER_A_CLEAR_EN enables the column-clear port.
// -----------------------------------------------------------------------------
module buffer_a_bank
   import buffer_pkg::*;
#(
   parameter int VAR_SIZE = 8,
   parameter int MMU_SIZE = 10,
   parameter int IW       = idx_width(MMU_SIZE)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [IW-1:0]                wr_slot,
   input  logic [IW-1:0]                wr_row,
   input  logic [IW-1:0]                wr_col,
   input  logic [VAR_SIZE-1:0]          wr_data,
`ifdef BUFFER_A_CLEAR_EN
   input  logic                         clr_en,
   input  logic [IW-1:0]                clr_slot,
   input  logic [IW-1:0]                clr_col,
`endif
   input  logic [IW-1:0]                rd_slot,
   input  logic [IW-1:0]                rd_col,
   output logic [VAR_SIZE*MMU_SIZE-1:0] rd_column
);

   logic [VAR_SIZE-1:0] mem [MMU_SIZE][MMU_SIZE][MMU_SIZE];

   // Storage update: reset wipes everything; the controller never asserts a
   // write and a column clear in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < MMU_SIZE; s++)
            for (int r = 0; r < MMU_SIZE; r++)
               for (int c = 0; c < MMU_SIZE; c++)
                  mem[IW'(s)][IW'(r)][IW'(c)] <= '0;
      end else begin
         if (wr_en)
            mem[wr_slot][wr_row][wr_col] <= wr_data;
`ifdef BUFFER_A_CLEAR_EN
         if (clr_en)
            for (int r = 0; r < MMU_SIZE; r++)
               mem[clr_slot][IW'(r)][clr_col] <= '0;
`endif
      end
   end

   // Column read port, packed row 0 in the least significant element.
   always_comb begin
      rd_column = '0;
      for (int r = 0; r < MMU_SIZE; r++)
         rd_column[r*VAR_SIZE +: VAR_SIZE] = mem[rd_slot][IW'(r)][rd_col];
   end

endmodule

// File: rtl/buffer_a.sv
// -----------------------------------------------------------------------------
// buffer_a
// Multi-slot matrix buffer. A matrix is loaded serially (column-major, row
// index fastest) into one of MMU_SIZE slots and later streamed out one column
// per clock on B1. Each slot remembers the dimensions it was loaded with.
// Ports:
//   clk, rst_n         : rising-edge clock, synchronous active-low reset
//   cmd                : 00 NONE, 01 LOAD, 10 SEND, 11 CLEAR (sampled in IDLE)
//   stop               : pause; freezes state, counters, writes and B1
//   buffer             : slot index
//   A                  : serial load element (signed)
//   dim_x_in, dim_y_in : columns / rows for a command (must be 1..MMU_SIZE)
//   B1                 : column output, row r at bits [VAR_SIZE*r +: VAR_SIZE]
//   dim_x, dim_y       : dimensions of the slot being sent
// Macro: BUFFER_A_CLEAR_EN enables the CLEAR command; without it cmd 11 is
// treated as NONE.
// -----------------------------------------------------------------------------
module buffer_a
   import buffer_pkg::*;
#(
   parameter int VAR_SIZE = 8,
   parameter int MMU_SIZE = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [1:0]                   cmd,
   input  logic                         stop,
   input  logic [4:0]                   buffer,
   input  logic signed [VAR_SIZE-1:0]   A,
   input  logic [$clog2(MMU_SIZE):0]    dim_x_in,
   input  logic [$clog2(MMU_SIZE):0]    dim_y_in,
   output logic [VAR_SIZE*MMU_SIZE-1:0] B1,
   output logic [$clog2(MMU_SIZE):0]    dim_x,
   output logic [$clog2(MMU_SIZE):0]    dim_y
);

   localparam int DW = $clog2(MMU_SIZE) + 1;
   localparam int IW = idx_width(MMU_SIZE);
   localparam logic [DW-1:0] MAX_DIM  = DW'(MMU_SIZE);
   localparam logic [DW-1:0] LAST_COL = DW'(MMU_SIZE - 1);
   localparam logic [DW-1:0] ONE      = DW'(1);

   state_t                       state_q, state_d;
   logic [DW-1:0]                row_q, row_d;
   logic [DW-1:0]                col_q, col_d;
   logic [DW-1:0]                ldx_q, ldx_d;
   logic [DW-1:0]                ldy_q, ldy_d;
   logic [IW-1:0]                slot_q, slot_d;
   logic [IW-1:0]                cmd_slot;
   logic [DW-1:0]                dim_x_d, dim_y_d;
   logic [VAR_SIZE*MMU_SIZE-1:0] b1_d;
   logic [VAR_SIZE*MMU_SIZE-1:0] rd_column;
   logic [DW-1:0]                stored_dx [MMU_SIZE];
   logic [DW-1:0]                stored_dy [MMU_SIZE];
   logic                         cmd_ok;
   logic                         wr_en;
   logic                         dim_wr_en;
`ifdef BUFFER_A_CLEAR_EN
   logic                         clr_en;
   logic                         dim_clr_en;
   logic [IW-1:0]                clr_slot;
   logic [IW-1:0]                clr_col;
`endif

   // A command is only legal with an existing slot and non-empty dimensions
   // that fit in a slot.
   assign cmd_slot = IW'(buffer);
   assign cmd_ok   = (32'(buffer) < MMU_SIZE) &&
                     (dim_x_in != '0) && (dim_x_in <= MAX_DIM) &&
                     (dim_y_in != '0) && (dim_y_in <= MAX_DIM);

   buffer_a_bank #(
      .VAR_SIZE (VAR_SIZE),
      .MMU_SIZE (MMU_SIZE),
      .IW       (IW)
   ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_slot   (slot_q),
      .wr_row    (IW'(row_q)),
      .wr_col    (IW'(col_q)),
      .wr_data   (A),
`ifdef BUFFER_A_CLEAR_EN
      .clr_en    (clr_en),
      .clr_slot  (clr_slot),
      .clr_col   (clr_col),
`endif
      .rd_slot   (slot_q),
      .rd_col    (IW'(col_q)),
      .rd_column (rd_column)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Counters, latched command fields, outputs and per-slot dimensions.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q  <= '0;
         col_q  <= '0;
         ldx_q  <= '0;
         ldy_q  <= '0;
         slot_q <= '0;
         B1     <= '0;
         dim_x  <= '0;
         dim_y  <= '0;
         for (int s = 0; s < MMU_SIZE; s++) begin
            stored_dx[IW'(s)] <= '0;
            stored_dy[IW'(s)] <= '0;
         end
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         ldx_q  <= ldx_d;
         ldy_q  <= ldy_d;
         slot_q <= slot_d;
         B1     <= b1_d;
         dim_x  <= dim_x_d;
         dim_y  <= dim_y_d;
         if (dim_wr_en) begin
            stored_dx[cmd_slot] <= dim_x_in;
            stored_dy[cmd_slot] <= dim_y_in;
         end
`ifdef BUFFER_A_CLEAR_EN
         if (dim_clr_en) begin
            stored_dx[cmd_slot] <= '0;
            stored_dy[cmd_slot] <= '0;
         end
`endif
      end
   end

   // Next-state and datapath control. stop holds every default, which freezes
   // the whole block at its current position.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      ldx_d     = ldx_q;
      ldy_d     = ldy_q;
      slot_d    = slot_q;
      b1_d      = B1;
      dim_x_d   = dim_x;
      dim_y_d   = dim_y;
      wr_en     = 1'b0;
      dim_wr_en = 1'b0;
`ifdef BUFFER_A_CLEAR_EN
      clr_en     = 1'b0;
      dim_clr_en = 1'b0;
      clr_slot   = slot_q;
      clr_col    = IW'(col_q);
`endif
      if (!stop) begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_ok) begin
                  case (cmd)
                     CMD_LOAD: begin
                        state_d   = ST_LOAD;
                        slot_d    = cmd_slot;
                        ldx_d     = dim_x_in;
                        ldy_d     = dim_y_in;
                        row_d     = '0;
                        col_d     = '0;
                        dim_wr_en = 1'b1;
                     end
                     CMD_SEND: begin
                        state_d = ST_SEND;
                        slot_d  = cmd_slot;
                        dim_x_d = stored_dx[cmd_slot];
                        dim_y_d = stored_dy[cmd_slot];
                        col_d   = '0;
                     end
`ifdef BUFFER_A_CLEAR_EN
                     // Column 0 is cleared on the sampling edge itself, so
                     // the CLEAR state only has columns 1..MMU_SIZE-1 left.
                     CMD_CLEAR: begin
                        state_d    = ST_CLEAR;
                        slot_d     = cmd_slot;
                        clr_en     = 1'b1;
                        clr_slot   = cmd_slot;
                        clr_col    = '0;
                        dim_clr_en = 1'b1;
                        col_d      = ONE;
                     end
`endif
                     default: ;
                  endcase
               end
            end
            // Column-major capture: row wraps first, the last element of
            // the last column ends the load.
            ST_LOAD: begin
               wr_en = 1'b1;
               if (row_q == ldy_q - ONE) begin
                  row_d = '0;
                  if (col_q == ldx_q - ONE) begin
                     col_d   = '0;
                     state_d = ST_IDLE;
                  end else begin
                     col_d = col_q + ONE;
                  end
               end else begin
                  row_d = row_q + ONE;
               end
            end
            // One column per edge; rows beyond the stored height are forced
            // to zero because older, larger loads may have left data there.
            ST_SEND: begin
               if (col_q < dim_x) begin
                  for (int r = 0; r < MMU_SIZE; r++)
                     b1_d[r*VAR_SIZE +: VAR_SIZE] = (r < int'(dim_y)) ?
                        rd_column[r*VAR_SIZE +: VAR_SIZE] : '0;
                  col_d = col_q + ONE;
               end else begin
                  b1_d    = '0;
                  col_d   = '0;
                  state_d = ST_IDLE;
               end
            end
`ifdef BUFFER_A_CLEAR_EN
            ST_CLEAR: begin
               clr_en = 1'b1;
               if (col_q == LAST_COL) begin
                  col_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  col_d = col_q + ONE;
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_buffer_a.sv
// -----------------------------------------------------------------------------
// tb_buffer_a
// Self-checking bench for buffer_a. A reference model holds every slot as a
// plain 3-D array plus per-slot dimensions; directed and random loads/sends
// are compared against it. Works with or without BUFFER_A_CLEAR_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_buffer_a;
   import buffer_pkg::*;

   localparam int VS = 8;
   localparam int MS = 10;
   localparam int DW = $clog2(MS) + 1;
   localparam int BW = VS * MS;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [1:0]           cmd;
   logic                 stop;
   logic [4:0]           buffer;
   logic signed [VS-1:0] A;
   logic [DW-1:0]        dim_x_in;
   logic [DW-1:0]        dim_y_in;
   logic [BW-1:0]        B1;
   logic [DW-1:0]        dim_x;
   logic [DW-1:0]        dim_y;

   logic [VS-1:0] ref_mem [MS][MS][MS];
   int            ref_dx [MS];
   int            ref_dy [MS];

   int n_cmp  = 0;
   int n_fail = 0;

   buffer_a #(
      .VAR_SIZE (VS),
      .MMU_SIZE (MS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd      (cmd),
      .stop     (stop),
      .buffer   (buffer),
      .A        (A),
      .dim_x_in (dim_x_in),
      .dim_y_in (dim_y_in),
      .B1       (B1),
      .dim_x    (dim_x),
      .dim_y    (dim_y)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [BW-1:0] obs,
                               input logic [BW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ref_reset();
      for (int s = 0; s < MS; s++) begin
         ref_dx[s] = 0;
         ref_dy[s] = 0;
         for (int r = 0; r < MS; r++)
            for (int c = 0; c < MS; c++)
               ref_mem[s][r][c] = '0;
      end
   endtask

   // Expected B1 for column c of a slot: stored rows below the height, 0 above.
   function automatic logic [BW-1:0] ref_column(input int slot, input int c);
      logic [BW-1:0] col;
      col = '0;
      for (int r = 0; r < ref_dy[slot]; r++)
         col[r*VS +: VS] = ref_mem[slot][r][c];
      return col;
   endfunction

   // kind 0: 10*r+c, kind 1: all -1, other: random. A pause of 3 cycles with
   // junk on A is inserted before element stop_at (no pause if out of range).
   task automatic apply_load(input int slot, input int dx, input int dy,
                             input int kind, input int stop_at);
      cmd      = CMD_LOAD;
      buffer   = 5'(slot);
      dim_x_in = DW'(dx);
      dim_y_in = DW'(dy);
      tick();
      cmd = CMD_NONE;
      ref_dx[slot] = dx;
      ref_dy[slot] = dy;
      for (int k = 0; k < dx * dy; k++) begin
         int r;
         int c;
         logic [VS-1:0] v;
         r = k % dy;
         c = k / dy;
         case (kind)
            0:       v = VS'(10 * r + c);
            1:       v = '1;
            default: v = VS'($urandom);
         endcase
         if (k == stop_at) begin
            stop = 1'b1;
            A    = 8'sh5A;
            repeat (3) tick();
            stop = 1'b0;
         end
         A = v;
         tick();
         ref_mem[slot][r][c] = v;
      end
      A = '0;
   endtask

   // SEND a slot and check dims, every column, and the return of B1 to 0.
   // After column stop_col the block is paused for 2 cycles; B1 must hold.
   task automatic apply_send(input int slot, input int stop_col, input string tag);
      cmd      = CMD_SEND;
      buffer   = 5'(slot);
      dim_x_in = DW'(1);
      dim_y_in = DW'(1);
      tick();
      cmd = CMD_NONE;
      check_output({tag, ".dim_x"}, BW'(dim_x), BW'(ref_dx[slot]));
      check_output({tag, ".dim_y"}, BW'(dim_y), BW'(ref_dy[slot]));
      for (int c = 0; c < ref_dx[slot]; c++) begin
         tick();
         check_output($sformatf("%s.col%0d", tag, c), B1, ref_column(slot, c));
         if (c == stop_col) begin
            stop = 1'b1;
            repeat (2) tick();
            check_output($sformatf("%s.hold%0d", tag, c), B1, ref_column(slot, c));
            stop = 1'b0;
         end
      end
      tick();
      check_output({tag, ".tail"}, B1, '0);
   endtask

   initial begin
      rst_n    = 1'b0;
      cmd      = CMD_NONE;
      stop     = 1'b0;
      buffer   = '0;
      A        = '0;
      dim_x_in = '0;
      dim_y_in = '0;
      ref_reset();

      // Reset state.
      repeat (2) tick();
      check_output("rst.B1", B1, '0);
      check_output("rst.dim_x", BW'(dim_x), '0);
      check_output("rst.dim_y", BW'(dim_y), '0);
      rst_n = 1'b1;
      tick();

      // Freshly reset slot reads back empty.
      apply_send(0, -1, "send_empty");

      // 5x5 pattern into slot 3, including a pause mid-send.
      apply_load(3, 5, 5, 0, -1);
      apply_send(3, 2, "send_pat");

      // Illegal slot index: must be ignored, slot 3 untouched.
      cmd      = CMD_LOAD;
      buffer   = 5'd12;
      dim_x_in = DW'(5);
      dim_y_in = DW'(5);
      tick();
      cmd = CMD_NONE;
      A   = 8'sh77;
      repeat (3) tick();
      A = '0;
      apply_send(3, -1, "bad_slot");

      // Illegal width on a real slot: must be ignored.
      cmd      = CMD_LOAD;
      buffer   = 5'd3;
      dim_x_in = DW'(11);
      dim_y_in = DW'(5);
      tick();
      cmd = CMD_NONE;
      A   = 8'sh66;
      repeat (3) tick();
      A = '0;
      apply_send(3, -1, "bad_dim");

      // CLEAR held for MMU_SIZE cycles; a no-op when the feature is absent.
      cmd      = CMD_CLEAR;
      buffer   = 5'd3;
      dim_x_in = DW'(5);
      dim_y_in = DW'(5);
      repeat (MS) tick();
      cmd = CMD_NONE;
`ifdef BUFFER_A_CLEAR_EN
      ref_dx[3] = 0;
      ref_dy[3] = 0;
      for (int r = 0; r < MS; r++)
         for (int c = 0; c < MS; c++)
            ref_mem[3][r][c] = '0;
`endif
      apply_send(3, -1, "after_clear");

      // All -1 with a pause mid-load: pause must not inject data.
      apply_load(2, 5, 5, 1, 12);
      apply_send(2, -1, "neg_stop");

      // Small 3 columns x 2 rows matrix.
      apply_load(1, 3, 2, 2, -1);
      apply_send(1, -1, "small3x2");

      // Random loads and sends.
      for (int i = 0; i < 6; i++) begin
         int s;
         int dx;
         int dy;
         s  = $urandom_range(0, MS - 1);
         dx = $urandom_range(1, MS);
         dy = $urandom_range(1, MS);
         apply_load(s, dx, dy, 2, $urandom_range(0, dx * dy));
         apply_send(s, $urandom_range(0, MS - 1), $sformatf("rnd%0d", i));
         apply_send($urandom_range(0, MS - 1), -1, $sformatf("rnd%0d_other", i));
      end

      // Reset during a SEND, with stop also asserted: reset wins.
      apply_load(2, 5, 5, 1, -1);
      cmd      = CMD_SEND;
      buffer   = 5'd2;
      dim_x_in = DW'(1);
      dim_y_in = DW'(1);
      tick();
      cmd = CMD_NONE;
      tick();
      check_output("mid.col0", B1, ref_column(2, 0));
      rst_n = 1'b0;
      stop  = 1'b1;
      tick();
      check_output("mid_rst.B1", B1, '0);
      check_output("mid_rst.dim_x", BW'(dim_x), '0);
      check_output("mid_rst.dim_y", BW'(dim_y), '0);
      rst_n = 1'b1;
      stop  = 1'b0;
      ref_reset();
      tick();
      apply_send(2, -1, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/buffer_a.md
BUFFER_A -- requirements
Module: buffer_a

Interface
REQ-001 SHALL have parameter VAR_SIZE, default 8: element width in bits, signed two's complement.
REQ-002 SHALL have parameter MMU_SIZE, default 10: max matrix dimension and number of buffer slots.
REQ-003 SHALL have one clock and a synchronous, active-low reset, ports: clk input 1 (rising edge); rst_n input 1.
REQ-004 SHALL have ports: cmd input 2 (00 NONE, 01 LOAD, 10 SEND, 11 CLEAR); stop input 1 (pause); buffer input 5 (slot index).
REQ-005 SHALL have ports: A input signed VAR_SIZE (serial load element); B1 output VAR_SIZE*MMU_SIZE (column vector).
REQ-006 SHALL have ports: dim_x_in and dim_y_in, inputs, $clog2(MMU_SIZE)+1 bits each (columns, rows); dim_x and dim_y, outputs, same width.

Function
REQ-007 SHALL store MMU_SIZE slots of MMU_SIZE x MMU_SIZE elements, plus dim_x/dim_y per slot.
REQ-008 SHALL sample cmd only in IDLE; commands in LOAD/SEND/CLEAR states are ignored, except CLEAR continuing a CLEAR.
REQ-009 SHALL ignore any command with buffer >= MMU_SIZE, or with dim_x_in or dim_y_in equal to 0 or above MMU_SIZE; the block stays IDLE.
REQ-010 LOAD: at edge E0 the block latches slot, dim_x_in and dim_y_in; on edges E1..E(dx*dy) it captures A in column-major order (row index fastest), into element [row][col]; then IDLE.
REQ-011 SEND: at edge E0 the block latches slot and drives dim_x/dim_y with that slot's stored dims; at edge E(c+1), c = 0..dx-1, B1 is loaded with column c.
REQ-012 B1 packing: row r occupies bits [VAR_SIZE*r +: VAR_SIZE]; rows >= dy are 0.
REQ-013 After the last column of a SEND, B1 returns to 0 on the next edge and the block returns to IDLE.
REQ-014 CLEAR: from the edge sampling it, the block zeroes one column of the selected slot per edge for MMU_SIZE edges, and also zeroes that slot's dims; then IDLE.
REQ-015 stop=1 SHALL freeze state, counters, storage writes and B1; when stop is released the operation resumes at the same position.
REQ-016 A LOAD to a slot SHALL overwrite only elements within dx x dy; other elements keep their values.
REQ-017 FSM states: IDLE, LOAD, SEND, CLEAR; the transitions are those in REQ-010..REQ-015.

Reset
REQ-018 On an edge with rst_n=0: B1=0, dim_x=0, dim_y=0, state IDLE, counters 0, all storage and stored dims 0.
REQ-019 Reset during any operation SHALL abort it within that edge, and SHALL take priority over stop.

Configuration
REQ-020 Macro BUFFER_A_CLEAR_EN: when defined, CLEAR behaves per REQ-014; when undefined, cmd 11 is treated as NONE and no clear logic is synthesized.

Structure
REQ-021 A shared package buffer_pkg SHALL hold the cmd encoding constants (CMD_NONE/LOAD/SEND/CLEAR) and the FSM state enum.
REQ-022 Storage SHALL be a sub-module buffer_a_bank (element write port and column read port); control and FSM stay in buffer_a.

Verification
REQ-023 Reset, then SEND slot 0 -> B1 = 0 for all columns, dim_x = 0, dim_y = 0.
REQ-024 LOAD slot 3 with a 5x5 matrix where element[r][c] = 10*r + c (serial, column-major), then SEND slot 3 -> edge E(c+1) gives B1 row r = 10*r + c, rows 5..9 = 0, dim_x = dim_y = 5.
REQ-025 Same load, then CLEAR slot 3 held for 10 cycles, then SEND -> every column is 0 (macro defined).
REQ-026 LOAD slot 2 with values -1 (0xFF) while stop=1 for 3 cycles mid-load, then SEND -> all 25 elements read back as -1 and the pause inserts no extra data.
REQ-027 LOAD with buffer = 12, or with dim_x_in = 11 -> command ignored and the slot is unchanged.
REQ-028 LOAD slot 1 with a 3x2 matrix, then SEND -> 3 columns output, rows 2..9 = 0, and B1 = 0 one edge after the third column.
